// File: rtl/dcache_arb_pkg.sv
// rtl/dcache_arb_pkg.sv - shared types and constants for the load/store dcache arbiter
package dcache_arb_pkg;

  localparam int ADDR_W_DEF       = 64;
  localparam int DATA_W_DEF       = 64;
  localparam int MASK_W_DEF       = 64;
  localparam int OPT_W_DEF        = 2;
  localparam int STARVE_LIMIT_DEF = 8;

  // State encodings are fixed so they line up with existing debug tooling.
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] BUSY_LD = 2'b01;
  localparam logic [1:0] BUSY_ST = 2'b10;
  localparam logic [1:0] DRAIN   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_BUSY_LD = BUSY_LD,
    ST_BUSY_ST = BUSY_ST,
    ST_DRAIN   = DRAIN
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_LD   = 2'b01,
    OWN_ST   = 2'b10
  } owner_e;

  typedef enum logic [OPT_W_DEF-1:0] {
    TBUS_READ  = 2'b00,
    TBUS_WRITE = 2'b01
  } tbus_op_e;

  // A drained load has no owner left to receive its response.
  function automatic owner_e state_owner(input arb_state_e s);
    case (s)
      ST_BUSY_LD: state_owner = OWN_LD;
      ST_BUSY_ST: state_owner = OWN_ST;
      default:    state_owner = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dcache_arb_if.sv
// rtl/dcache_arb_if.sv - one tbus request/response channel
interface dcache_arb_if
  import dcache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = MASK_W_DEF,
  parameter int OPT_W  = OPT_W_DEF
);

  logic              tbus_index_valid;
  logic              tbus_index_ready;
  logic [ADDR_W-1:0] tbus_index;
  logic [DATA_W-1:0] tbus_write_data;
  logic [MASK_W-1:0] tbus_write_mask;
  logic [OPT_W-1:0]  tbus_operation_type;
  logic [DATA_W-1:0] tbus_read_data;
  logic              tbus_operation_done;

  // Requestor side: issues the request, receives the response.
  modport master (
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    input  tbus_index_ready, tbus_read_data, tbus_operation_done
  );

  // Responder side: accepts the request, returns the response.
  modport slave (
    input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    output tbus_index_ready, tbus_read_data, tbus_operation_done
  );

endinterface

// File: rtl/dcache_arb_starve_ctr.sv
// rtl/dcache_arb_starve_ctr.sv - saturating count of cycles a store waits for a grant
module dcache_arb_starve_ctr
  import dcache_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;

  // Clear wins over increment; the count parks at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sat = (cnt >= LIMIT);

endmodule

// File: rtl/dcache_arb.sv
// rtl/dcache_arb.sv - load unit / store queue arbiter onto the single dcache tbus port
module dcache_arb
  import dcache_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MASK_W       = MASK_W_DEF,
  parameter int OPT_W        = OPT_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load2arb_flush_valid,
  dcache_arb_if.slave  load2arb,
  dcache_arb_if.slave  sq2arb,
  dcache_arb_if.master arb2dcache
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  owner_e            owner;

  logic              ld_eff;
  logic              in_idle;
  logic              sel_ld;
  logic              sel_st;
  logic              fire;
  logic              starve_sat;
  logic              ld_done;
  logic              st_done;

  logic [ADDR_W-1:0] mux_index;
  logic [DATA_W-1:0] mux_wdata;
  logic [MASK_W-1:0] mux_wmask;
  logic [OPT_W-1:0]  mux_optype;
  logic [DATA_W-1:0] ld_rdata;
  logic [DATA_W-1:0] st_rdata;

  // Grant select: store wins when load is absent/flushed or the store has starved.
  // reset_n gates the grant so nothing is presented while reset is held.
  always_comb begin
    ld_eff  = load2arb.tbus_index_valid & ~load2arb_flush_valid;
    in_idle = reset_n & (state == ST_IDLE);
    sel_st  = in_idle & sq2arb.tbus_index_valid & (~ld_eff | starve_sat);
    sel_ld  = in_idle & ld_eff & ~sel_st;
    fire    = (sel_ld | sel_st) & arb2dcache.tbus_index_ready;
  end

  dcache_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (sel_st & fire),
    .inc     ((state == ST_IDLE) & sq2arb.tbus_index_valid & ~(sel_st & fire)),
    .sat     (starve_sat)
  );

  // Request mux: unselected fields read as zero.
  always_comb begin
    mux_index  = '0;
    mux_wdata  = '0;
    mux_wmask  = '0;
    mux_optype = '0;
    if (sel_st) begin
      mux_index  = sq2arb.tbus_index;
      mux_wdata  = sq2arb.tbus_write_data;
      mux_wmask  = sq2arb.tbus_write_mask;
      mux_optype = sq2arb.tbus_operation_type;
    end else if (sel_ld) begin
      mux_index  = load2arb.tbus_index;
      mux_wdata  = load2arb.tbus_write_data;
      mux_wmask  = load2arb.tbus_write_mask;
      mux_optype = load2arb.tbus_operation_type;
    end
  end

  assign arb2dcache.tbus_index_valid    = sel_ld | sel_st;
  assign arb2dcache.tbus_index          = mux_index;
  assign arb2dcache.tbus_write_data     = mux_wdata;
  assign arb2dcache.tbus_write_mask     = mux_wmask;
  assign arb2dcache.tbus_operation_type = mux_optype;
  assign load2arb.tbus_index_ready      = sel_ld & arb2dcache.tbus_index_ready;
  assign sq2arb.tbus_index_ready        = sel_st & arb2dcache.tbus_index_ready;

  // Response routing: only the owner of the outstanding transaction sees done.
  // A flush landing with the done cycle kills the load response.
  always_comb begin
    owner    = state_owner(state);
    ld_done  = reset_n & (owner == OWN_LD) & arb2dcache.tbus_operation_done & ~load2arb_flush_valid;
    st_done  = reset_n & (owner == OWN_ST) & arb2dcache.tbus_operation_done;
    ld_rdata = ld_done ? arb2dcache.tbus_read_data : '0;
    st_rdata = st_done ? arb2dcache.tbus_read_data : '0;
  end

  assign load2arb.tbus_operation_done = ld_done;
  assign load2arb.tbus_read_data      = ld_rdata;
  assign sq2arb.tbus_operation_done   = st_done;
  assign sq2arb.tbus_read_data        = st_rdata;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: one transaction in flight; a flushed load drains before returning to idle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fire) state_nxt = sel_st ? ST_BUSY_ST : ST_BUSY_LD;
      end
      ST_BUSY_LD: begin
        if (arb2dcache.tbus_operation_done) state_nxt = ST_IDLE;
        else if (load2arb_flush_valid)      state_nxt = ST_DRAIN;
      end
      ST_BUSY_ST: begin
        if (arb2dcache.tbus_operation_done) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (arb2dcache.tbus_operation_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The dcache must never complete a transaction that was not issued.
  a_no_spurious_done: assert property (
    @(posedge clock) disable iff (!reset_n)
    !((state == ST_IDLE) && arb2dcache.tbus_operation_done)
  );

endmodule

// File: doc/dcache_arb.md
Name: dcache_arb

Overview:
- Two-requestor trinity-bus arbiter between the load unit and the store-queue commit port.
- Drives a single tbus request channel into the dcache.
- Holds one transaction outstanding at a time, records which requestor owns it, and routes operation_done and read_data back to that owner only.
- Absorbs load-side flushes by draining and discarding an orphaned load response.

Parameters:
- ADDR_W, 64, tbus index width (RESULT_RANGE)
- DATA_W, 64, write/read data width (SRC_RANGE / RESULT_RANGE)
- MASK_W, 64, write mask width
- OPT_W, 2, tbus operation type width (TBUS_OPTYPE_RANGE)
- STARVE_LIMIT, 8, cycles a blocked store waits before it overrides load priority

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load2arb_tbus_index_valid  in  1  load request valid
- load2arb_tbus_index_ready  out  1  load request accepted
- load2arb_tbus_index  in  ADDR_W  load address
- load2arb_tbus_write_data  in  DATA_W  load write data (unused by dcache for reads, forwarded)
- load2arb_tbus_write_mask  in  MASK_W  load write mask (forwarded)
- load2arb_tbus_operation_type  in  OPT_W  load op type
- load2arb_tbus_read_data  out  DATA_W  read data to load unit
- load2arb_tbus_operation_done  out  1  load transaction complete
- load2arb_flush_valid  in  1  load unit flushed; drop its transaction
- sq2arb_tbus_index_valid  in  1  store request valid
- sq2arb_tbus_index_ready  out  1  store request accepted
- sq2arb_tbus_index  in  ADDR_W  store address
- sq2arb_tbus_write_data  in  DATA_W  store data
- sq2arb_tbus_write_mask  in  MASK_W  store byte-lane mask
- sq2arb_tbus_operation_type  in  OPT_W  store op type
- sq2arb_tbus_read_data  out  DATA_W  read data to SQ
- sq2arb_tbus_operation_done  out  1  store transaction complete
- arb2dcache_tbus_index_valid  out  1  request to dcache
- arb2dcache_tbus_index_ready  in  1  dcache accepts
- arb2dcache_tbus_index  out  ADDR_W  muxed address
- arb2dcache_tbus_write_data  out  DATA_W  muxed data
- arb2dcache_tbus_write_mask  out  MASK_W  muxed mask
- arb2dcache_tbus_operation_type  out  OPT_W  muxed op type
- arb2dcache_tbus_read_data  in  DATA_W  dcache read data
- arb2dcache_tbus_operation_done  in  1  dcache transaction complete

Behaviour:
- FSM states: IDLE, BUSY_LD, BUSY_ST, DRAIN. Reset puts it in IDLE with starve_cnt=0.
- All valid, ready and done outputs reset to 0. Data outputs are 0 whenever not selected.
- IDLE, grant select (combinational, zero added latency):
  - Load is masked when load2arb_flush_valid=1.
  - sel_st = sq_valid & (~ld_eff | starve_cnt>=STARVE_LIMIT); otherwise sel_ld = ld_eff.
  - Selected request's fields drive arb2dcache_*; arb2dcache_tbus_index_valid = sel_ld|sel_st.
  - Selected requestor's ready = arb2dcache_tbus_index_ready; the other requestor's ready = 0.
- Fire = arb2dcache valid & ready.
  - On fire, go to BUSY_LD or BUSY_ST.
  - When the fire is a store, starve_cnt resets to 0.
- starve_cnt: in IDLE, increments (saturating at STARVE_LIMIT) each cycle sq valid is not granted-and-fired. Holds in other states.
- Not IDLE: arb2dcache valid=0 and both readies=0. Single outstanding transaction.
- BUSY_LD:
  - arb2dcache done -> load2arb_tbus_operation_done=1 same cycle; read_data passed through. Next state IDLE.
  - load2arb_flush_valid without done -> DRAIN.
  - Flush and done in the same cycle -> done suppressed, next state IDLE.
- BUSY_ST: arb2dcache done -> sq2arb_tbus_operation_done=1, read_data passed through, next state IDLE. Load flush ignored in this state.
- DRAIN: wait for arb2dcache done; neither done output asserted; then IDLE. Further flushes ignored.
- No new grant in the cycle a done returns; the next request can fire the following cycle.
- Done never reaches the non-owner. Spurious dcache done in IDLE is ignored; sim-only assertion.
- Reset mid-transaction returns to IDLE immediately. The dcache is reset in the same domain.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'b00, BUSY_LD=2'b01, BUSY_ST=2'b10, DRAIN=2'b11)
  - owner enum
  - TBUS_READ/TBUS_WRITE op codes, reused from defines.sv
- One natural sub-module: dcache_arb_starve_ctr, the saturating starvation counter with clear/inc/sat-flag.

Test Plan:
- Load only: ld valid, idx=0x80, dcache ready=1 -> arb idx=0x80 same cycle, ld ready=1, state BUSY_LD; done with rdata=0xDEAD -> ld done=1, ld rdata=0xDEAD, sq done=0.
- Both valid in IDLE with starve_cnt=0 -> load granted; sq ready=0; store granted in the first IDLE cycle after load done if load is not re-requesting.
- Load held valid continuously and store valid for 8 IDLE cycles -> ninth arbitration grants store (sq ready=1), starve_cnt returns 0.
- Load fires, flush pulses 2 cycles later, dcache done 5 cycles later -> state DRAIN, ld done stays 0, sq done stays 0, IDLE the cycle after done.
- Flush and done in the same BUSY_LD cycle -> ld done=0, next state IDLE. Flush in IDLE with ld and sq valid -> store granted.
- reset_n deasserted (driven to 0) during BUSY_ST -> all valid/ready/done=0 immediately; after reset_n returns to 1, a new load request fires normally.
